// File: rtl/ldm_stm_seq.sv
// Multi-cycle sequencer for Thumb STM/LDM/PUSH/POP: one data_mem word access per
// listed register, load data steered to the register file a cycle later, then one writeback cycle.
module ldm_stm_seq #(
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [8:0]  reg_list,
  input  logic [2:0]  base_idx,
  input  logic [31:0] base_addr,
  output logic        stall,
  output logic        busy,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [6:0]  mem_opcode,
  output logic [3:0]  rf_rd_idx,
  output logic        rf_wr_en,
  output logic [3:0]  rf_wr_idx,
  output logic        base_wb_en,
  output logic [31:0] base_wb_val,
  output logic        done
);

  localparam logic [1:0] OP_STM  = 2'b00;
  localparam logic [1:0] OP_LDM  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WB} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  list_q, list_d;
  logic [8:0]  pend_q, pend_d;
  logic [2:0]  base_idx_q, base_idx_d;
  logic [31:0] base_addr_q, base_addr_d;
  logic [31:0] span_q, span_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic        ld_pend_q, ld_pend_d;
  logic [3:0]  ld_idx_q, ld_idx_d;

  logic [8:0]  list_in;
  logic [3:0]  n_in;
  logic [31:0] span_in;
  logic [8:0]  low_onehot;
  logic [8:0]  pend_rest;
  logic [3:0]  low_bit;
  logic [3:0]  cur_idx;
  logic        is_load;
  logic [6:0]  opcode_q;

  // Bit 8 (LR/PC) only has meaning for PUSH/POP.
  assign list_in  = op[1] ? reg_list : {1'b0, reg_list[7:0]};
  assign n_in     = 4'($countones(list_in));
  assign span_in  = {28'd0, n_in} * ADDR_STEP;

  assign low_onehot = pend_q & (~pend_q + 9'd1);
  assign pend_rest  = pend_q & ~low_onehot;
  assign is_load    = op_q[0];

  always_comb begin
    low_bit = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (low_onehot[i]) low_bit = 4'(i);
    end
  end

  assign cur_idx = (low_bit == 4'd8) ? (op_q[0] ? 4'd15 : 4'd14) : low_bit;

  always_comb begin
    case (op_q)
      OP_STM:  opcode_q = 7'b1100000;
      OP_LDM:  opcode_q = 7'b1100100;
      OP_PUSH: opcode_q = 7'b1011010;
      default: opcode_q = 7'b1011110;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      list_q      <= 8'd0;
      pend_q      <= 9'd0;
      base_idx_q  <= 3'd0;
      base_addr_q <= 32'd0;
      span_q      <= 32'd0;
      n_q         <= 4'd0;
      addr_q      <= 32'd0;
      ld_pend_q   <= 1'b0;
      ld_idx_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      list_q      <= list_d;
      pend_q      <= pend_d;
      base_idx_q  <= base_idx_d;
      base_addr_q <= base_addr_d;
      span_q      <= span_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      ld_pend_q   <= ld_pend_d;
      ld_idx_q    <= ld_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    list_d       = list_q;
    pend_d       = pend_q;
    base_idx_d   = base_idx_q;
    base_addr_d  = base_addr_q;
    span_d       = span_q;
    n_d          = n_q;
    addr_d       = addr_q;
    ld_pend_d    = 1'b0;
    ld_idx_d     = 4'd0;
    stall        = 1'b0;
    busy         = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'd0;
    mem_opcode   = 7'd0;
    rf_rd_idx    = 4'd0;
    base_wb_en   = 1'b0;
    base_wb_val  = 32'd0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall       = 1'b1;
          op_d        = op;
          list_d      = list_in[7:0];
          pend_d      = list_in;
          base_idx_d  = base_idx;
          base_addr_d = base_addr;
          span_d      = span_in;
          n_d         = n_in;
          addr_d      = (op == OP_PUSH) ? base_addr - span_in : base_addr;
          state_d     = (n_in == 4'd0) ? S_WB : S_ISSUE;
        end
      end

      S_ISSUE: begin
        stall        = 1'b1;
        busy         = 1'b1;
        mem_addr     = addr_q;
        mem_opcode   = opcode_q;
        mem_write_en = ~is_load;
        rf_rd_idx    = is_load ? 4'd0 : cur_idx;
        // data_mem read is registered, so the destination index trails by one cycle.
        ld_pend_d    = is_load;
        ld_idx_d     = is_load ? cur_idx : 4'd0;
        addr_d       = addr_q + ADDR_STEP;
        pend_d       = pend_rest;
        if (pend_rest == 9'd0) begin
          state_d = is_load ? S_DRAIN : S_WB;
        end
      end

      S_DRAIN: begin
        stall   = 1'b1;
        busy    = 1'b1;
        state_d = S_WB;
      end

      S_WB: begin
        busy        = 1'b1;
        done        = 1'b1;
        // A loaded base register overrides the incremented address.
        base_wb_en  = (n_q != 4'd0) && !((op_q == OP_LDM) && list_q[base_idx_q]);
        base_wb_val = (op_q == OP_PUSH) ? base_addr_q - span_q : base_addr_q + span_q;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rf_wr_en  = ld_pend_q;
  assign rf_wr_idx = ld_idx_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: data_mem and register file models plus a
// per-cycle expectation derived from the block-transfer rules.
module tb_ldm_stm_seq;

  localparam logic [1:0] OP_STM  = 2'b00;
  localparam logic [1:0] OP_LDM  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;
  localparam logic [31:0] STEP   = 32'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [8:0]  reg_list = 9'd0;
  logic [2:0]  base_idx = 3'd0;
  logic [31:0] base_addr = 32'd0;
  logic        stall, busy, mem_write_en, rf_wr_en, base_wb_en, done;
  logic [31:0] mem_addr, base_wb_val;
  logic [6:0]  mem_opcode;
  logic [3:0]  rf_rd_idx, rf_wr_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ldm_stm_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .reg_list     (reg_list),
    .base_idx     (base_idx),
    .base_addr    (base_addr),
    .stall        (stall),
    .busy         (busy),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_opcode   (mem_opcode),
    .rf_rd_idx    (rf_rd_idx),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_idx    (rf_wr_idx),
    .base_wb_en   (base_wb_en),
    .base_wb_val  (base_wb_val),
    .done         (done)
  );

  // Environment: word-indexed data_mem with registered read, and a register file.
  logic [31:0] mem [0:255];
  logic [31:0] rf_tb [0:15];
  logic [31:0] mem_rdata;
  logic        fill_en = 1'b0;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:0]];
    if (fill_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= $urandom;
      for (int i = 0; i < 16; i++) rf_tb[i] <= $urandom;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write_en) begin
      mem[mem_addr[7:0]] <= rf_tb[rf_rd_idx];
    end
    if (rf_wr_en && !fill_en) rf_tb[rf_wr_idx] <= mem_rdata;
  end

  logic [84:0] obs_vec;
  assign obs_vec = {stall, busy, mem_write_en, mem_addr, mem_opcode, rf_rd_idx,
                    rf_wr_en, rf_wr_idx, base_wb_en, base_wb_val, done};

  // Reference expectation for one operation.
  logic [84:0] exp_vec [0:15];
  logic [3:0]  mreg [0:8];
  int          mn;
  int          mdone;
  logic [31:0] mstart;
  logic        m_wben;
  logic        m_store;
  logic [31:0] mem_snap [0:255];
  logic [31:0] rf_snap [0:15];

  int          obs_done_c, obs_done_cnt, obs_we_cnt;
  logic        obs_wben_seen;
  logic [31:0] obs_wb_val;

  task automatic compute_model(input logic [1:0] m_op, input logic [8:0] m_list,
                               input logic [2:0] m_bidx, input logic [31:0] m_base);
    logic [6:0]  opc;
    logic [31:0] wbv;
    logic        e_stall, e_busy, e_we, e_rfwe, e_wben, e_done;
    logic [31:0] e_addr, e_val;
    logic [6:0]  e_opc;
    logic [3:0]  e_rd, e_rfidx;
    m_store = (m_op == OP_STM) || (m_op == OP_PUSH);
    mn = 0;
    for (int b = 0; b < 8; b++) begin
      if (m_list[b]) begin
        mreg[mn] = 4'(b);
        mn++;
      end
    end
    if (m_op[1] && m_list[8]) begin
      mreg[mn] = (m_op == OP_POP) ? 4'd15 : 4'd14;
      mn++;
    end
    mstart = (m_op == OP_PUSH) ? m_base - 32'(mn) * STEP : m_base;
    case (m_op)
      OP_STM:  opc = 7'b1100000;
      OP_LDM:  opc = 7'b1100100;
      OP_PUSH: opc = 7'b1011010;
      default: opc = 7'b1011110;
    endcase
    mdone  = (mn == 0) ? 1 : (m_store ? mn + 1 : mn + 2);
    m_wben = (mn != 0) && !((m_op == OP_LDM) && m_list[m_bidx]);
    wbv    = (m_op == OP_PUSH) ? m_base - 32'(mn) * STEP : m_base + 32'(mn) * STEP;
    for (int c = 0; c <= mdone + 1; c++) begin
      e_stall = 0; e_busy = 0; e_we = 0; e_rfwe = 0; e_wben = 0; e_done = 0;
      e_addr = 0; e_val = 0; e_opc = 0; e_rd = 0; e_rfidx = 0;
      if (c == 0) e_stall = 1;
      if (c >= 1 && c <= mn) begin
        e_stall = 1;
        e_busy  = 1;
        e_we    = m_store;
        e_addr  = mstart + 32'(c - 1) * STEP;
        e_opc   = opc;
        e_rd    = m_store ? mreg[c - 1] : 4'd0;
      end
      if (!m_store && c >= 2 && c <= mn + 1) begin
        e_rfwe  = 1;
        e_rfidx = mreg[c - 2];
      end
      if (!m_store && mn > 0 && c == mn + 1) begin
        e_stall = 1;
        e_busy  = 1;
      end
      if (c == mdone) begin
        e_busy = 1;
        e_done = 1;
        e_wben = m_wben;
        e_val  = m_wben ? wbv : 32'd0;
      end
      exp_vec[c] = {e_stall, e_busy, e_we, e_addr, e_opc, e_rd, e_rfwe, e_rfidx, e_wben, e_val, e_done};
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that opens
  // the first IDLE cycle (or the one after it when check_idle is set).
  task automatic run_op(input logic [1:0] r_op, input logic [8:0] r_list, input logic [2:0] r_bidx,
                        input logic [31:0] r_base, input int busy_at, input bit check_idle);
    logic [84:0] o;
    int diffs;
    compute_model(r_op, r_list, r_bidx, r_base);
    for (int i = 0; i < 256; i++) mem_snap[i] = mem[i];
    for (int i = 0; i < 16; i++) rf_snap[i] = rf_tb[i];
    obs_done_c = -1; obs_done_cnt = 0; obs_we_cnt = 0; obs_wben_seen = 0; obs_wb_val = 0;
    $display("txn op=%0d list=%03h base_idx=%0d base=%08h n=%0d busy_start=%0d",
             r_op, r_list, r_bidx, r_base, mn, busy_at);
    start = 1; op = r_op; reg_list = r_list; base_idx = r_bidx; base_addr = r_base;
    for (int c = 0; c <= mdone; c++) begin
      @(negedge clk);
      o = obs_vec;
      if (mem_write_en) obs_we_cnt++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_c < 0) obs_done_c = c;
      end
      if (base_wb_en) begin
        obs_wben_seen = 1;
        obs_wb_val = base_wb_val;
      end
      if (c == mdone && !m_wben) o[32:1] = 32'h0;
      checks++;
      if (o !== exp_vec[c]) begin
        failures++;
        $display("FAIL cycle_outputs op=%0d cycle=%0d actual=%h expected=%h", r_op, c, o, exp_vec[c]);
      end
      @(posedge clk); #1;
      start    = (c + 1 == busy_at) && (c + 1 <= mdone);
      op       = 2'($urandom);
      reg_list = 9'($urandom);
      base_idx = 3'($urandom);
      base_addr = $urandom;
    end
    if (check_idle) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec[mdone + 1]) begin
        failures++;
        $display("FAIL idle_after_done op=%0d actual=%h expected=%h", r_op, obs_vec, exp_vec[mdone + 1]);
      end
      @(posedge clk); #1;
    end
    diffs = 0;
    for (int k = 0; k < mn; k++) begin
      if (m_store) begin
        if (mem[8'(mstart + 32'(k) * STEP)] !== rf_snap[mreg[k]]) diffs++;
      end else begin
        if (rf_tb[mreg[k]] !== mem_snap[8'(mstart + 32'(k) * STEP)]) diffs++;
      end
    end
    checks++;
    if (diffs != 0) begin
      failures++;
      $display("FAIL data_transfer op=%0d wrong_words=%0d required=0", r_op, diffs);
    end
  endtask

  task automatic do_fill();
    fill_en = 1;
    @(posedge clk); #1;
    fill_en = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_we = 1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec !== 85'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0", obs_vec);
    end
    @(posedge clk); #1;
    rst = 0;
    do_fill();
  endtask

  task automatic test_push();
    run_op(OP_PUSH, 9'h105, 3'd0, 32'h100, 0, 1);
    checks++;
    if (obs_done_c != 4) begin
      failures++;
      $display("FAIL push_done_cycle actual=%0d required=4", obs_done_c);
    end
    checks++;
    if (obs_wb_val !== 32'hFD || obs_wben_seen !== 1'b1) begin
      failures++;
      $display("FAIL push_wb actual_en=%0d actual_val=%h required_en=1 required_val=fd", obs_wben_seen, obs_wb_val);
    end
    checks++;
    if (mem[8'hFF] !== rf_tb[14]) begin
      failures++;
      $display("FAIL push_lr_word actual=%h required=%h", mem[8'hFF], rf_tb[14]);
    end
  endtask

  task automatic test_pop();
    preload(8'hFD, 32'h11);
    preload(8'hFE, 32'h22);
    run_op(OP_POP, 9'h102, 3'd0, 32'hFD, 0, 1);
    checks++;
    if (rf_tb[1] !== 32'h11 || rf_tb[15] !== 32'h22) begin
      failures++;
      $display("FAIL pop_data actual_r1=%h actual_pc=%h required_r1=11 required_pc=22", rf_tb[1], rf_tb[15]);
    end
    checks++;
    if (obs_done_c != 4 || obs_wb_val !== 32'hFF) begin
      failures++;
      $display("FAIL pop_done_wb actual_cycle=%0d actual_val=%h required_cycle=4 required_val=ff", obs_done_c, obs_wb_val);
    end
  endtask

  task automatic test_ldm_base_in_list();
    run_op(OP_LDM, 9'h028, 3'd3, 32'h40, 0, 1);
    checks++;
    if (obs_wben_seen !== 1'b0 || obs_done_c != 4) begin
      failures++;
      $display("FAIL ldm_base_in_list actual_wben=%0d actual_cycle=%0d required_wben=0 required_cycle=4", obs_wben_seen, obs_done_c);
    end
  endtask

  task automatic test_empty();
    run_op(OP_STM, 9'h000, 3'd2, $urandom, 0, 1);
    checks++;
    if (obs_done_c != 1 || obs_we_cnt != 0 || obs_wben_seen !== 1'b0) begin
      failures++;
      $display("FAIL empty_list actual_cycle=%0d actual_writes=%0d actual_wben=%0d required=1/0/0", obs_done_c, obs_we_cnt, obs_wben_seen);
    end
  endtask

  task automatic test_reset_mid();
    int diffs;
    $display("txn op=1 list=01f reset_in_second_issue_cycle");
    start = 1; op = OP_LDM; reg_list = 9'h01F; base_idx = 3'd7; base_addr = $urandom;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) rf_snap[i] = rf_tb[i];
    rst = 1;
    #1;
    checks++;
    if (obs_vec !== 85'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs actual=%h required=0", obs_vec);
    end
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== 85'd0) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle=%0d actual=%h required=0", c, obs_vec);
      end
      @(posedge clk); #1;
    end
    diffs = 0;
    for (int i = 0; i < 16; i++) if (rf_tb[i] !== rf_snap[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      failures++;
      $display("FAIL reset_mid_rf_writes actual=%0d required=0", diffs);
    end
    run_op(OP_STM, 9'h0A6, 3'd1, $urandom, 0, 1);
  endtask

  task automatic test_start_busy();
    run_op(OP_STM, 9'h0F3, 3'd0, $urandom, 2, 1);
    checks++;
    if (obs_we_cnt != 6 || obs_done_cnt != 1) begin
      failures++;
      $display("FAIL start_while_busy actual_writes=%0d actual_dones=%0d required=6/1", obs_we_cnt, obs_done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_op(OP_PUSH, 9'h1C1, 3'd0, 32'h80, 0, 0);
    run_op(OP_POP, 9'h1C1, 3'd0, 32'h7C, 0, 0);
    run_op(OP_STM, 9'h000, 3'd0, 32'h10, 0, 0);
    run_op(OP_LDM, 9'h011, 3'd4, 32'h20, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int t = 0; t < 40; t++) begin
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      run_op(2'($urandom), 9'($urandom), 3'($urandom), b,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0,
             1'($urandom));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_ldm_base_in_list();
    test_empty();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-cycle sequencer for Thumb block transfers (STM, LDM, PUSH, POP) against `data_mem`. It sits between decode/execute and `data_mem`. On a start request it stalls the pipeline and issues one word access per listed register. For loads it steers the read data back to the register file one cycle later, then produces the base/SP writeback value and a done pulse.

## Interface
- `ADDR_STEP`, default 1: `mem_addr` increment per transfer (data memory is word-indexed).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 STM, 01 LDM, 10 PUSH, 11 POP.
- `reg_list` in 9: bits 7:0 select r0–r7. Bit 8 is LR for PUSH, PC for POP, and ignored for STM/LDM.
- `base_idx` in 3: base register index (STM/LDM only).
- `base_addr` in 32: base register value (SP for PUSH/POP).
- `stall` out 1: freeze upstream pipeline.
- `busy` out 1: state ≠ IDLE.
- `mem_write_en` out 1: to `data_mem`.
- `mem_addr` out 32: to `data_mem`.
- `mem_opcode` out 7: to `data_mem` opCode. Values: PUSH 7'b1011010, POP 7'b1011110, STM 7'b1100000, LDM 7'b1100100; 0 when not issuing.
- `rf_rd_idx` out 4: register whose value drives `mem_data_in` this cycle (stores).
- `rf_wr_en` out 1: write load data (`mem_data_out`) to the register file.
- `rf_wr_idx` out 4: destination register; bit 8 maps to 14 (LR) or 15 (PC).
- `base_wb_en` out 1: write `base_wb_val` to the base/SP register.
- `base_wb_val` out 32: updated base.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, WB.
- **Capture.** In IDLE with `start`=1, the block latches `op`, masked list (bit 8 cleared for STM/LDM), `base_idx`, `base_addr`, and N = popcount(list), 0..9.
- **Empty list.** If the list is empty: go to WB with `base_wb_en`=0.
- **Start address.** PUSH starts at `base_addr` − N·ADDR_STEP. STM, LDM and POP start at `base_addr`. All arithmetic is mod 2^32.
- **ISSUE.** One transfer per cycle. Registers are visited in ascending index order, lowest register at the lowest address. `mem_addr` increments by ADDR_STEP each cycle.
  - Stores (STM/PUSH): `mem_write_en`=1 and `rf_rd_idx` = current register.
  - Loads (LDM/POP): `mem_write_en`=0.
- **Leaving ISSUE** after the N-th transfer: loads go to DRAIN, stores go to WB.
- **Load return.** For every load issued in cycle k, `rf_wr_en`=1 and `rf_wr_idx` = that register in cycle k+1. This matches the `data_mem` registered read. The last return occurs in DRAIN.
- **WB** (one cycle), then IDLE:
  - `done`=1.
  - `base_wb_en`=1 and `base_wb_val` = `base_addr` − N·ADDR_STEP for PUSH, `base_addr` + N·ADDR_STEP otherwise.
  - Exception: LDM with the base register in the list gives `base_wb_en`=0, because the loaded value wins.
- **Start while busy:** ignored; not queued.
- **rf write collisions:** the block never asserts `rf_wr_en` and `base_wb_en` in the same cycle.

## Timing
- **Reset.** State IDLE; every output is 0, including `mem_opcode` and `base_wb_val`. A pending load return is discarded. Reset mid-operation aborts immediately and leaves no partial writeback.
- **`stall`** is combinational: high in the IDLE cycle that accepts `start` (any N), and in all ISSUE and DRAIN cycles. It is low in WB, so the block instruction retires on the WB edge.
- **First access:** in the cycle after the start edge.
- **Latency, start cycle to `done`:**
  - Stores: N+1 cycles.
  - Loads: N+2 cycles.
  - N=0: 1 cycle.
- **`busy`** is high from the first ISSUE (or WB) cycle through WB.
- **`mem_opcode`** is held constant for all ISSUE cycles of one operation and is 0 in DRAIN and WB.
- Back-to-back operations: `start` is accepted in the first IDLE cycle after WB.

## Test plan
- **PUSH.** {r0,r2,LR}, `base_addr`=0x100 → stores at 0xFD (r0), 0xFE (r2), 0xFF (rd_idx 14) over 3 cycles. Then WB with `base_wb_val`=0xFD; `done` 4 cycles after start.
- **POP.** {r1,PC}, base 0xFD, memory preloaded with 0x11 and 0x22 → `rf_wr_en` with idx 1 / data 0x11, then idx 15 / data 0x22, each one cycle after the matching address. Then `base_wb_val`=0xFF; `done` at start+4.
- **LDM with base in list.** `base_idx`=3, list {r3,r5}, base 0x40 → two loads; `base_wb_en` stays 0; `done` at start+4.
- **Empty list.** STM, `reg_list`=0 → no `mem_write_en`; `stall` high in the start cycle only; `done` at start+1 with `base_wb_en`=0.
- **Reset mid-operation.** `rst` asserted during the 2nd ISSUE cycle of a 5-register LDM → all outputs 0 immediately, no further `rf_wr_en`. A new STM started afterwards completes normally.
- **Start while busy.** `start` pulsed mid-STM → ignored; exactly N `mem_write_en` cycles and one `done`.
